// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with open-drain line control, ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  typedef enum logic [3:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE, DONE} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] clk_sync, data_sync;
  logic clk_prev, clk_s, data_s, fall, expired;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [8:0] sh, sh_n;
  logic clk_oe_n, data_oe_n, ack_err_n, timeout_err_n;
  assign clk_s = clk_sync[2];
  assign data_s = data_sync[2];
  assign fall = clk_prev & ~clk_s;
  assign expired = cnt == TMO_LAST;
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      clk_sync <= '1;
      data_sync <= '1;
      clk_prev <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      ack_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      clk_prev <= clk_s;
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      ack_err <= ack_err_n;
      timeout_err <= timeout_err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    clk_oe_n = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    ack_err_n = ack_err;
    timeout_err_n = timeout_err;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = INHIBIT;
        cnt_n = '0;
        sh_n = {~^tx_data, tx_data};
        clk_oe_n = 1'b1;
        data_oe_n = INHIBIT_CYCLES == 1;
        ack_err_n = 1'b0;
        timeout_err_n = 1'b0;
      end
      INHIBIT: begin
        cnt_n = cnt + ONE;
        data_oe_n = cnt + ONE == INH_LAST;
        if (cnt == INH_LAST) begin
          state_n = REQ;
          cnt_n = '0;
          bit_cnt_n = '0;
          clk_oe_n = 1'b0;
          data_oe_n = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        cnt_n = fall ? '0 : cnt + ONE;
        bit_cnt_n = fall ? bit_cnt + 4'd1 : bit_cnt;
        if (state == WAIT_IDLE && clk_s && data_s) state_n = DONE;
        else if (fall) begin
          if (state inside {REQ, DATA, PARITY}) begin
            data_oe_n = ~sh[0];
            sh_n = {1'b0, sh[8:1]};
          end
          if (state == STOP) data_oe_n = 1'b0;
          if (state == ACK) ack_err_n = data_s;
          state_n = state == REQ ? DATA :
                    state == DATA ? (bit_cnt == 4'd7 ? PARITY : DATA) :
                    state == PARITY ? STOP :
                    state == STOP ? ACK :
                    state == ACK ? WAIT_IDLE : state;
        end else if (expired) begin
          state_n = DONE;
          clk_oe_n = 1'b0;
          data_oe_n = 1'b0;
          ack_err_n = 1'b0;
          timeout_err_n = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized host-to-device PS/2 transfers against an open-drain device model and frame reference
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  int total = 0;
  int bad = 0;
  int run = 0, dhi = 0, last_run = 0, last_dhi = 0, excl_bad = 0, done_cnt = 0;
  logic last_d = 1'b0, last_last_d = 1'b0;
  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done && tx_ready) excl_bad <= excl_bad + 1;
    if (ps2_clk_oe === 1'b1) begin
      run <= run + 1;
      dhi <= dhi + (ps2_data_oe ? 1 : 0);
      last_d <= ps2_data_oe;
    end else if (run != 0) begin
      last_run <= run;
      last_dhi <= dhi;
      last_last_d <= last_d;
      run <= 0;
      dhi <= 0;
    end
  end
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction
  task automatic dev_frame(input bit do_ack, input int n, output logic [10:0] seen, output bit ok);
    int t;
    t = 0;
    seen = '0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    ok = t < 1000;
    if (!ok) return;
    repeat (10) @(negedge clk);
    seen[0] = ps2_data_line;
    for (int k = 1; k <= n; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (k <= 10) seen[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      if (k < n) begin
        if (k == 10 && do_ack) begin
          repeat (10) @(negedge clk);
          dev_data_low = 1'b1;
          repeat (10) @(negedge clk);
        end else repeat (20) @(negedge clk);
      end
    end
    if (do_ack) begin
      repeat (2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask
  task automatic xfer(input logic [7:0] b, input bit do_ack, output logic [10:0] seen, output logic [4:0] obs);
    int t;
    bit ok;
    @(negedge clk);
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(do_ack, 11, seen, ok);
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    obs[4:1] = {done & ok, ack_err, timeout_err, ~(ps2_clk_oe | ps2_data_oe)};
    @(negedge clk);
    obs[0] = tx_ready;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout_err} !== 7'b0010000) begin
      bad++;
      $display("FAIL reset_state got=%b want=0010000", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout_err});
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({tx_ready, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=100", {tx_ready, busy, done});
    end
  endtask
  task automatic test_led;
    logic [10:0] seen;
    logic [4:0] obs;
    xfer(8'hED, 1'b1, seen, obs);
    total++;
    if (seen !== frame_of(8'hED)) begin
      bad++;
      $display("FAIL frame_ed got=%b want=%b", seen, frame_of(8'hED));
    end
    total++;
    if (obs !== 5'b10011) begin
      bad++;
      $display("FAIL flags_ed got=%b want=10011", obs);
    end
    total++;
    if (last_run !== INH) begin
      bad++;
      $display("FAIL inhibit_len got=%0d want=%0d", last_run, INH);
    end
    total++;
    if ({last_dhi == 1, last_last_d} !== 2'b11) begin
      bad++;
      $display("FAIL inhibit_data got=%0d/%b want=1/1", last_dhi, last_last_d);
    end
  endtask
  task automatic test_parity;
    logic [10:0] seen;
    logic [4:0] obs;
    logic [7:0] bytes [2];
    bytes[0] = 8'hF4;
    bytes[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      xfer(bytes[i], 1'b1, seen, obs);
      total++;
      if (seen[9] !== frame_of(bytes[i])[9]) begin
        bad++;
        $display("FAIL parity_%h got=%b want=%b", bytes[i], seen[9], frame_of(bytes[i])[9]);
      end
      total++;
      if ({seen, obs} !== {frame_of(bytes[i]), 5'b10011}) begin
        bad++;
        $display("FAIL frame_%h got=%b/%b want=%b/10011", bytes[i], seen, obs, frame_of(bytes[i]));
      end
    end
  endtask
  task automatic test_random;
    logic [10:0] seen;
    logic [4:0] obs;
    logic [7:0] b;
    bit a;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      a = 1'($urandom_range(1, 0));
      xfer(b, a, seen, obs);
      total++;
      if (seen !== frame_of(b)) begin
        bad++;
        $display("FAIL rand_frame_%h got=%b want=%b", b, seen, frame_of(b));
      end
      total++;
      if (obs !== {1'b1, ~a, 3'b011}) begin
        bad++;
        $display("FAIL rand_flags_%h got=%b want=%b", b, obs, {1'b1, ~a, 3'b011});
      end
    end
  endtask
  task automatic test_nack;
    logic [10:0] seen;
    logic [4:0] obs;
    bit ok;
    int t;
    xfer(8'h3A, 1'b0, seen, obs);
    total++;
    if (obs !== 5'b11011) begin
      bad++;
      $display("FAIL nack_flags got=%b want=11011", obs);
    end
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if ({busy, ack_err} !== 2'b10) begin
      bad++;
      $display("FAIL ack_err_clear got=%b want=10", {busy, ack_err});
    end
    dev_frame(1'b1, 11, seen, ok);
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    total++;
    if ({seen, done, ack_err, timeout_err} !== {frame_of(8'hFF), 3'b100}) begin
      bad++;
      $display("FAIL frame_ff got=%b/%b want=%b/100", seen, {done, ack_err, timeout_err}, frame_of(8'hFF));
    end
    @(negedge clk);
  endtask
  task automatic test_timeout;
    int t;
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t !== TMO) begin
      bad++;
      $display("FAIL timeout_delay got=%0d want=%0d", t, TMO);
    end
    total++;
    if ({ps2_clk_oe, ps2_data_oe, timeout_err, ack_err, tx_ready} !== 5'b00100) begin
      bad++;
      $display("FAIL timeout_flags got=%b want=00100", {ps2_clk_oe, ps2_data_oe, timeout_err, ack_err, tx_ready});
    end
    @(negedge clk);
    total++;
    if ({tx_ready, busy, timeout_err} !== 3'b101) begin
      bad++;
      $display("FAIL timeout_idle got=%b want=101", {tx_ready, busy, timeout_err});
    end
  endtask
  task automatic test_reset_mid;
    logic [10:0] seen;
    logic [4:0] obs;
    bit ok;
    int dc;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(1'b0, 5, seen, ok);
    total++;
    if ({ok, busy, seen[5:0]} !== {2'b11, frame_of(8'hA5)[5:0]}) begin
      bad++;
      $display("FAIL mid_bits got=%b want=%b", {ok, busy, seen[5:0]}, {2'b11, frame_of(8'hA5)[5:0]});
    end
    #2;
    dc = done_cnt;
    resetn = 1'b0;
    #1;
    total++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, tx_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL mid_reset got=%b want=00001", {ps2_clk_oe, ps2_data_oe, busy, done, tx_ready});
    end
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt !== dc) begin
      bad++;
      $display("FAIL mid_no_done got=%0d want=%0d", done_cnt, dc);
    end
    xfer(8'h3C, 1'b1, seen, obs);
    total++;
    if ({seen, obs} !== {frame_of(8'h3C), 5'b10011}) begin
      bad++;
      $display("FAIL after_reset got=%b/%b want=%b/10011", seen, obs, frame_of(8'h3C));
    end
  endtask
  task automatic test_back_to_back;
    logic [10:0] seen;
    bit ok;
    int t;
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    dev_frame(1'b1, 11, seen, ok);
    total++;
    if (seen !== frame_of(8'hAA)) begin
      bad++;
      $display("FAIL b2b_first got=%b want=%b", seen, frame_of(8'hAA));
    end
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    total++;
    if ({done, busy, tx_ready} !== 3'b110) begin
      bad++;
      $display("FAIL b2b_done got=%b want=110", {done, busy, tx_ready});
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if ({busy, tx_ready} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_accept got=%b want=10", {busy, tx_ready});
    end
    dev_frame(1'b1, 11, seen, ok);
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    total++;
    if ({seen, done, ack_err, timeout_err} !== {frame_of(8'h55), 3'b100}) begin
      bad++;
      $display("FAIL b2b_second got=%b/%b want=%b/100", seen, {done, ack_err, timeout_err}, frame_of(8'h55));
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_led;
    test_parity;
    test_random;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    total++;
    if (excl_bad !== 0) begin
      bad++;
      $display("FAIL done_with_ready got=%0d want=0", excl_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
